// File: rtl/avmm_led_bargraph_master.sv
// Avalon-MM initiator: polls an ADC sample register every PERIOD cycles and
// writes the matching 4-LED thermometer code to the LED PIO data register.
module avmm_led_bargraph_master #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] SRC_ADDR = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] DST_ADDR = ADDR_W'(32'h0000_0010),
  parameter int unsigned       SAMPLE_W = 12,
  parameter int unsigned       PERIOD   = 50000,
  parameter int unsigned       TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [31:0]         avm_writedata,
  output logic [3:0]          avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [31:0]         avm_readdata,
  input  logic                avm_readdatavalid,
  output logic [3:0]          led_code,
  output logic [SAMPLE_W-1:0] last_sample,
  output logic [15:0]         sample_count,
  output logic                timeout_err,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, RD_REQ, RD_WAIT, WR_REQ} state_t;

  localparam int unsigned TICK_W = $clog2(PERIOD);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(PERIOD - 1);
  localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ZERO   = TO_W'(0);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

  state_t            state_r;
  logic [TICK_W-1:0] tick_r;
  logic [TO_W-1:0]   to_r;
  logic              unused_rdata_s;

  assign avm_byteenable = 4'hF;
  assign unused_rdata_s = ^avm_readdata[31:SAMPLE_W];

  // lit = (sample*5) >> SAMPLE_W; sample*5 is formed as (sample<<2)+sample
  function automatic logic [3:0] therm_code(input logic [SAMPLE_W-1:0] sample);
    logic [SAMPLE_W+2:0] prod;
    logic [2:0]          lit;
    prod = {1'b0, sample, 2'b00} + {3'b000, sample};
    lit  = prod[SAMPLE_W+2:SAMPLE_W];
    case (lit)
      3'd0:    therm_code = 4'b0000;
      3'd1:    therm_code = 4'b0001;
      3'd2:    therm_code = 4'b0011;
      3'd3:    therm_code = 4'b0111;
      default: therm_code = 4'b1111;
    endcase
  endfunction

  // Poll sequencer: tick counter, bus requests, sample capture and status
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      tick_r        <= TICK_ZERO;
      to_r          <= TO_ZERO;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= {ADDR_W{1'b0}};
      avm_writedata <= 32'h0000_0000;
      led_code      <= 4'h0;
      last_sample   <= {SAMPLE_W{1'b0}};
      sample_count  <= 16'h0000;
      timeout_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      // The period counter keeps running through a transaction so poll
      // starts stay PERIOD apart; it parks at zero if a transaction overruns.
      if (tick_r != TICK_ZERO) begin
        tick_r <= tick_r - TICK_ONE;
      end
      case (state_r)
        IDLE: begin
          tick_r <= TICK_LOAD;
          if (enable) begin
            state_r     <= RD_REQ;
            avm_read    <= 1'b1;
            avm_address <= SRC_ADDR;
            busy        <= 1'b1;
          end
        end
        WAIT_TICK: begin
          if (!enable) begin
            state_r <= IDLE;
          end else if (tick_r == TICK_ZERO) begin
            state_r     <= RD_REQ;
            tick_r      <= TICK_LOAD;
            avm_read    <= 1'b1;
            avm_address <= SRC_ADDR;
            busy        <= 1'b1;
          end
        end
        RD_REQ: begin
          if (!avm_waitrequest) begin
            state_r  <= RD_WAIT;
            avm_read <= 1'b0;
            to_r     <= TO_ZERO;
          end
        end
        RD_WAIT: begin
          if (avm_readdatavalid) begin
            state_r       <= WR_REQ;
            last_sample   <= avm_readdata[SAMPLE_W-1:0];
            avm_write     <= 1'b1;
            avm_address   <= DST_ADDR;
            avm_writedata <= {28'h000_0000, therm_code(avm_readdata[SAMPLE_W-1:0])};
          end else if (to_r == TO_LAST) begin
            state_r     <= WAIT_TICK;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
          end else begin
            to_r <= to_r + TO_ONE;
          end
        end
        WR_REQ: begin
          if (!avm_waitrequest) begin
            state_r      <= enable ? WAIT_TICK : IDLE;
            avm_write    <= 1'b0;
            led_code     <= avm_writedata[3:0];
            sample_count <= sample_count + 16'd1;
            busy         <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_led_bargraph_master.sv
// Scoreboard bench: a behavioural Avalon slave feeds samples and queues the
// expected LED writes, which are checked as the master's writes complete.
module tb_avmm_led_bargraph_master;

  localparam int          PERIOD  = 8;
  localparam int          TIMEOUT = 4;
  localparam logic [31:0] SRC     = 32'h0000_0000;
  localparam logic [31:0] DST     = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;
  logic [3:0]  led_code;
  logic [11:0] last_sample;
  logic [15:0] sample_count;
  logic        timeout_err;
  logic        busy;

  avmm_led_bargraph_master #(
    .ADDR_W(32), .SRC_ADDR(SRC), .DST_ADDR(DST), .SAMPLE_W(12),
    .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .led_code(led_code),
    .last_sample(last_sample), .sample_count(sample_count),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_code(input int s);
    int lit;
    logic [4:0] v;
    lit = (s * 5) / 4096;
    v = 5'((1 << lit) - 1);
    return v[3:0];
  endfunction

  typedef struct { int smp; logic [3:0] code; } exp_t;
  exp_t exp_q[$];
  int   smp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave configuration (driven by the stimulus process)
  int rd_wait_cfg = 0, wr_wait_cfg = 0, rd_lat = 1;
  bit drop = 1'b0, spacing = 1'b1;
  // slave / scoreboard state
  bit          rd_busy = 0, wr_busy = 0, rd_acc = 0, wr_acc = 0, to_arm = 0;
  int          rd_left = 0, wr_left = 0, rdv_cnt = 0, last_start = -1, to_cyc = 0;
  int          reads = 0, writes = 0, rd_starts = 0, timeouts = 0, exp_cnt = 0;
  logic [31:0] rd_addr_s, wr_addr_s, wr_data_s, rd_data;
  logic [3:0]  exp_led = 4'h0;
  logic        exp_to = 1'b0;

  // Avalon slave model and scoreboard, driven/sampled on the falling edge
  always @(negedge clk) begin
    avm_readdatavalid = 1'b0;
    if (reset) begin
      rd_busy = 0; wr_busy = 0; rd_acc = 0; wr_acc = 0; to_arm = 0; rdv_cnt = 0;
      avm_waitrequest = 1'b0; last_start = -1; exp_cnt = 0; exp_led = 4'h0; exp_to = 1'b0;
      exp_q.delete();
    end else begin
      if (rd_acc) begin
        rd_acc = 0; rd_busy = 0; reads++;
        check_eq("rd_single", avm_read, 1'b0);
        check_eq("rd_addr", rd_addr_s, SRC);
        if (drop) begin
          to_arm = 1; to_cyc = cyc;
        end else begin
          exp_t e;
          e.smp  = (smp_q.size() > 0) ? smp_q.pop_front() : 0;
          e.code = model_code(e.smp);
          exp_q.push_back(e);
          rd_data = {20'($urandom), 12'(e.smp)};
          rdv_cnt = rd_lat;
        end
      end
      if (rdv_cnt > 0) begin
        rdv_cnt--;
        if (rdv_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = rd_data;
        end
      end
      if (to_arm && cyc == to_cyc + 3) check_eq("to_not_early", timeout_err, exp_to);
      if (to_arm && cyc == to_cyc + 4) begin
        exp_to = 1'b1; to_arm = 0; timeouts++;
        check_eq("to_set", timeout_err, exp_to);
        check_eq("to_led_hold", led_code, exp_led);
        check_eq("to_cnt_hold", sample_count, exp_cnt);
        check_eq("to_not_busy", busy, 1'b0);
      end
      if (wr_acc) begin
        wr_acc = 0; wr_busy = 0; writes++;
        check_eq("wr_single", avm_write, 1'b0);
        check_eq("wr_addr", wr_addr_s, DST);
        check_eq("wr_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          exp_cnt++; exp_led = e.code;
          check_eq("wr_data", wr_data_s, {28'h0, e.code});
          check_eq("led_code", led_code, e.code);
          check_eq("sample_count", sample_count, exp_cnt);
          check_eq("last_sample", last_sample, e.smp);
        end
      end
      avm_waitrequest = 1'b0;
      if (rd_busy) begin
        check_eq("rd_hold", avm_read, 1'b1);
        check_eq("rd_addr_hold", avm_address, rd_addr_s);
      end else if (avm_read) begin
        rd_busy = 1; rd_left = rd_wait_cfg; rd_addr_s = avm_address; rd_starts++;
        if (spacing && last_start >= 0) check_eq("poll_spacing", 32'(cyc - last_start), PERIOD);
        last_start = cyc;
      end
      if (wr_busy) begin
        check_eq("wr_hold", avm_write, 1'b1);
        check_eq("wr_addr_hold", avm_address, wr_addr_s);
        check_eq("wr_data_hold", avm_writedata, wr_data_s);
      end else if (avm_write) begin
        wr_busy = 1; wr_left = wr_wait_cfg; wr_addr_s = avm_address; wr_data_s = avm_writedata;
      end
      if (rd_busy) begin
        if (rd_left > 0) begin avm_waitrequest = 1'b1; rd_left--; end
        else rd_acc = 1;
      end
      if (wr_busy) begin
        if (wr_left > 0) begin avm_waitrequest = 1'b1; wr_left--; end
        else wr_acc = 1;
      end
      if (avm_read || avm_write) check_eq("rw_overlap", avm_read & avm_write, 1'b0);
    end
  end

  task automatic wait_writes(input int target, input int budget);
    for (int i = 0; i < budget && writes < target; i++) begin
      @(posedge clk); #2;
    end
    check_eq("wait_writes", writes, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_read"}, avm_read, 1'b0);
    check_eq({tag, "_write"}, avm_write, 1'b0);
    check_eq({tag, "_addr"}, avm_address, 32'h0);
    check_eq({tag, "_wdata"}, avm_writedata, 32'h0);
    check_eq({tag, "_be"}, avm_byteenable, 4'hF);
    check_eq({tag, "_led"}, led_code, 4'h0);
    check_eq({tag, "_sample"}, last_sample, 12'h0);
    check_eq({tag, "_count"}, sample_count, 16'h0);
    check_eq({tag, "_timeout"}, timeout_err, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  int samples [9] = '{0, 819, 820, 1639, 2457, 2458, 3276, 3277, 4095};

  initial begin
    int tgt, starts_snap;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    foreach (samples[i]) smp_q.push_back(samples[i]);
    reset = 1'b0;
    enable = 1'b1;
    wait_writes(9, 200);

    // stalled read and write: transaction overruns the period
    spacing = 1'b0; rd_wait_cfg = 3; wr_wait_cfg = 3;
    smp_q.push_back(2000); smp_q.push_back(3000);
    wait_writes(11, 100);

    // read with no data return
    rd_wait_cfg = 0; wr_wait_cfg = 0; drop = 1'b1;
    for (int i = 0; i < 60 && timeouts < 1; i++) begin @(posedge clk); #2; end
    check_eq("wait_timeout", timeouts, 1);
    drop = 1'b0;
    smp_q.push_back(1000);
    wait_writes(12, 60);
    check_eq("to_sticky", timeout_err, 1'b1);

    // enable drops while the read is outstanding
    rd_lat = 3;
    smp_q.push_back(4095);
    tgt = reads + 1;
    for (int i = 0; i < 60 && reads < tgt; i++) begin @(posedge clk); #2; end
    check_eq("wait_read", reads, tgt);
    enable = 1'b0;
    wait_writes(13, 40);
    starts_snap = rd_starts;
    repeat (30) begin @(posedge clk); #2; end
    check_eq("idle_no_reads", rd_starts, starts_snap);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_led", led_code, 4'hF);
    check_eq("idle_to_sticky", timeout_err, 1'b1);

    // reset while a write is stalled
    rd_lat = 1; wr_wait_cfg = 10;
    smp_q.push_back(3000);
    enable = 1'b1;
    for (int i = 0; i < 40 && !avm_write; i++) begin @(posedge clk); #2; end
    check_eq("wr_seen", avm_write, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    check_reset_outputs("midrst");
    wr_wait_cfg = 0;
    smp_q.push_back(1639);
    reset = 1'b0;
    wait_writes(14, 40);
    check_eq("post_rst_to", timeout_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
